// File: rtl/timer2.sv
// timer2: PIC16F Timer2 -- 8-bit TMR2 with PR2 period match,
// 1/4/16 prescaler and 1..16 postscaler feeding PIR1.TMR2IF.
//
// Ports:
//   clk, rst        core clock, synchronous active-high reset
//   tick            instruction-cycle enable; counting only when high
//   tmr2_wr_en      write d to TMR2 (clears prescaler/postscaler)
//   pr2_wr_en       write d to PR2
//   t2con_wr_en     write d[6:0] to T2CON (clears prescaler/postscaler)
//   d               write data
//   tmr2_q, pr2_q   register read-back
//   t2con_q         {1'b0, TOUTPS[3:0], TMR2ON, T2CKPS[1:0]}
//   tmr2_match      one-clk pulse after TMR2 reloads on period match
//   tmr2if_strobe   one-clk pulse at postscaler terminal count
module timer2 #(
    parameter logic [7:0] PR2_RESET   = 8'hFF,
    parameter logic [6:0] T2CON_RESET = 7'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       tmr2_wr_en,
    input  logic       pr2_wr_en,
    input  logic       t2con_wr_en,
    input  logic [7:0] d,
    output logic [7:0] tmr2_q,
    output logic [7:0] pr2_q,
    output logic [7:0] t2con_q,
    output logic       tmr2_match,
    output logic       tmr2if_strobe
);

    logic [7:0] tmr2;
    logic [7:0] pr2;
    logic [6:0] t2con;
    logic [3:0] pre;
    logic [3:0] post;
    logic       match;
    logic       strobe;

    logic [3:0] pre_max;
    logic       tmr2_on;
    logic       advance;
    logic       inc_ev;
    logic       at_pr;
    logic       post_tc;

    assign tmr2_on = t2con[2];

    // Terminal value of the prescaler count for the selected ratio.
    always_comb begin
        pre_max = 4'd0;
        case (t2con[1:0])
            2'b00:   pre_max = 4'd0;
            2'b01:   pre_max = 4'd3;
            default: pre_max = 4'd15;
        endcase
    end

    // A TMR2 or T2CON write owns the cycle, so counting is held off.
    assign advance = tick && tmr2_on && !tmr2_wr_en && !t2con_wr_en;
    assign inc_ev  = advance && (pre == pre_max);
    // Compare against the current PR2; a PR2 write this cycle
    // only takes effect for later compares.
    assign at_pr   = (tmr2 == pr2);
    assign post_tc = (post == t2con[6:3]);

    always_ff @(posedge clk) begin
        if (rst) begin
            tmr2   <= 8'h00;
            pr2    <= PR2_RESET;
            t2con  <= T2CON_RESET;
            pre    <= 4'd0;
            post   <= 4'd0;
            match  <= 1'b0;
            strobe <= 1'b0;
        end else begin
            match  <= 1'b0;
            strobe <= 1'b0;
            if (pr2_wr_en) begin
                pr2 <= d;
            end
            if (t2con_wr_en) begin
                t2con <= d[6:0];
                pre   <= 4'd0;
                post  <= 4'd0;
            end
            if (tmr2_wr_en) begin
                tmr2 <= d;
                pre  <= 4'd0;
                post <= 4'd0;
            end
            if (advance) begin
                if (inc_ev) begin
                    pre <= 4'd0;
                    if (at_pr) begin
                        tmr2  <= 8'h00;
                        match <= 1'b1;
                        if (post_tc) begin
                            post   <= 4'd0;
                            strobe <= 1'b1;
                        end else begin
                            post <= post + 4'd1;
                        end
                    end else begin
                        tmr2 <= tmr2 + 8'd1;
                    end
                end else begin
                    pre <= pre + 4'd1;
                end
            end
        end
    end

    assign tmr2_q        = tmr2;
    assign pr2_q         = pr2;
    assign t2con_q       = {1'b0, t2con};
    assign tmr2_match    = match;
    assign tmr2if_strobe = strobe;

endmodule

// File: tb/tb_timer2.sv
// tb_timer2: scoreboard bench for timer2; a cycle model queues
// expected outputs per driven cycle, popped after the clock edge.
module tb_timer2;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       tmr2_wr_en;
    logic       pr2_wr_en;
    logic       t2con_wr_en;
    logic [7:0] d;
    logic [7:0] tmr2_q;
    logic [7:0] pr2_q;
    logic [7:0] t2con_q;
    logic       tmr2_match;
    logic       tmr2if_strobe;

    timer2 dut (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .tmr2_wr_en   (tmr2_wr_en),
        .pr2_wr_en    (pr2_wr_en),
        .t2con_wr_en  (t2con_wr_en),
        .d            (d),
        .tmr2_q       (tmr2_q),
        .pr2_q        (pr2_q),
        .t2con_q      (t2con_q),
        .tmr2_match   (tmr2_match),
        .tmr2if_strobe(tmr2if_strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    endtask

    // Reference model state
    logic [7:0] m_tmr;
    logic [7:0] m_pr;
    logic [6:0] m_con;
    int         m_pre;
    int         m_post;
    logic       m_match;
    logic       m_stb;

    logic [25:0] sb[$];
    int cyc_no   = 0;
    int last_stb = -1;
    int gap_exp  = 0;

    task automatic model(input logic r, t, wt, wp, wc,
                         input logic [7:0] dd);
        int ps;
        logic adv;
        if (r) begin
            m_tmr = 8'h00; m_pr = 8'hFF; m_con = 7'h00;
            m_pre = 0; m_post = 0; m_match = 0; m_stb = 0;
            return;
        end
        m_match = 0;
        m_stb   = 0;
        adv = t && m_con[2] && !wt && !wc;
        ps  = m_con[1] ? 16 : (m_con[0] ? 4 : 1);
        if (adv) begin
            if (m_pre + 1 == ps) begin
                m_pre = 0;
                if (m_tmr == m_pr) begin
                    m_tmr   = 8'h00;
                    m_match = 1;
                    if (m_post == int'(m_con[6:3])) begin
                        m_post = 0;
                        m_stb  = 1;
                    end else begin
                        m_post++;
                    end
                end else begin
                    m_tmr = m_tmr + 8'd1;
                end
            end else begin
                m_pre++;
            end
        end
        if (wp) m_pr = dd;
        if (wc) begin m_con = dd[6:0]; m_pre = 0; m_post = 0; end
        if (wt) begin m_tmr = dd; m_pre = 0; m_post = 0; end
    endtask

    task automatic cyc(input logic r, t, wt, wp, wc,
                       input logic [7:0] dd);
        logic [25:0] exp;
        rst = r; tick = t; tmr2_wr_en = wt;
        pr2_wr_en = wp; t2con_wr_en = wc; d = dd;
        model(r, t, wt, wp, wc, dd);
        sb.push_back({m_tmr, m_pr, 1'b0, m_con, m_match, m_stb});
        @(posedge clk);
        #1;
        cyc_no++;
        exp = sb.pop_front();
        chk("sb", 32'({tmr2_q, pr2_q, t2con_q, tmr2_match,
                      tmr2if_strobe}), 32'(exp));
        if (tmr2if_strobe) begin
            if (gap_exp != 0 && last_stb >= 0)
                chk("stb_gap", cyc_no - last_stb, gap_exp);
            last_stb = cyc_no;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(0, 1, 0, 0, 0, 8'h00);
    endtask

    initial begin
        int k;
        // Reset defaults
        cyc(1, 0, 0, 0, 0, 8'h00);
        cyc(1, 1, 0, 0, 0, 8'h00);
        chk("rst_tmr2", tmr2_q, 8'h00);
        chk("rst_pr2", pr2_q, 8'hFF);
        chk("rst_t2con", t2con_q, 8'h00);
        chk("rst_match", tmr2_match, 0);
        chk("rst_stb", tmr2if_strobe, 0);

        // Basic period: PR2=3, on, 1:1/1:1
        cyc(0, 1, 0, 1, 0, 8'h03);
        cyc(0, 1, 0, 0, 1, 8'h04);
        gap_exp = 4; last_stb = -1;
        run(20);

        // Prescale 1:4, postscale 1:2, tick every 4th clk
        cyc(0, 0, 0, 1, 0, 8'h01);
        cyc(0, 0, 1, 0, 1, 8'h0D);
        gap_exp = 64; last_stb = -1;
        for (int i = 0; i < 200; i++)
            cyc(0, (i % 4) == 3, 0, 0, 0, 8'h00);
        gap_exp = 0;

        // Overshoot wrap past 0xFF with PR2=0x10
        cyc(0, 1, 0, 1, 1, 8'h10);
        cyc(0, 1, 0, 0, 1, 8'h04);
        cyc(0, 1, 1, 0, 0, 8'hFE);
        chk("ovr_fe", tmr2_q, 8'hFE);
        run(40);

        // Prescaler cleared by TMR2 write
        cyc(0, 1, 0, 0, 1, 8'h06);
        run(10);
        cyc(0, 1, 1, 0, 0, 8'h05);
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            cyc(0, 1, 0, 0, 0, 8'h00);
            if (tmr2_q == 8'h06) begin k = i; break; end
        end
        chk("pre_clr", k, 16);

        // T2CON write while TMR2==PR2 blocks the match
        cyc(0, 1, 0, 1, 1, 8'h04);
        cyc(0, 1, 1, 0, 0, 8'h04);
        cyc(0, 1, 0, 0, 1, 8'h04);
        chk("blk_tmr2", tmr2_q, 8'h04);
        chk("blk_match", tmr2_match, 0);
        cyc(0, 1, 0, 0, 0, 8'h00);
        chk("unblk_match", tmr2_match, 1);
        chk("unblk_stb", tmr2if_strobe, 1);

        // Reset on a pending match
        cyc(0, 1, 1, 1, 0, 8'h07);
        cyc(1, 1, 0, 0, 0, 8'h00);
        chk("mrst_stb", tmr2if_strobe, 0);
        chk("mrst_pr2", pr2_q, 8'hFF);
        chk("mrst_tmr2", tmr2_q, 8'h00);
        cyc(0, 1, 0, 0, 0, 8'h00);
        chk("mrst_stb2", tmr2if_strobe, 0);
        chk("mrst_con", t2con_q, 8'h00);
        run(4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
